// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external dual-port SRAM with a 2-entry output skid buffer.
// Optional SRAM_FIFO_CTRL_LEVEL_EN adds a registered occupancy output `level`.
module sram_fifo_ctrl #(
  parameter int WIDTH    = 128,
  parameter int NUM_ROWS = 4096,
  localparam int AddressWidth = $clog2(NUM_ROWS)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sram_REB,
  output logic                    sram_WEB,
  output logic [AddressWidth-1:0] sram_AA,
  output logic [AddressWidth-1:0] sram_AB,
  output logic [WIDTH-1:0]        sram_D,
  output logic [WIDTH-1:0]        sram_M,
  input  logic [WIDTH-1:0]        sram_Q
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [$clog2(NUM_ROWS+3)-1:0] level
`endif
);

  localparam int StoredWidth = $clog2(NUM_ROWS + 1);
  localparam logic [AddressWidth-1:0] LastRow   = AddressWidth'(NUM_ROWS - 1);
  localparam logic [StoredWidth-1:0]  FullCount = StoredWidth'(NUM_ROWS);

  logic [AddressWidth-1:0] wr_ptr, wr_ptr_nx;
  logic [AddressWidth-1:0] rd_ptr, rd_ptr_nx;
  logic [StoredWidth-1:0]  stored, stored_nx;
  logic [1:0]              occ, occ_nx;
  logic                    head, head_nx;
  logic                    inflight, inflight_nx;
  logic [WIDTH-1:0]        obuf [2];

  logic push, pop, issue, tail;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AddressWidth-1:0] next_ptr(input logic [AddressWidth-1:0] p);
    return (p == LastRow) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (stored < FullCount) & ~clr;
  assign push      = in_valid & in_ready & RST_N;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = obuf[head];

  // Issue only if the returning word is guaranteed a free buffer slot.
  assign issue = (stored != '0) & ~clr &
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  // occ <= 1 whenever inflight is set, so head ^ occ[0] is always a free slot.
  assign tail = head ^ occ[0];

  assign sram_WEB = ~push;
  assign sram_AA  = wr_ptr;
  assign sram_D   = in_data;
  assign sram_M   = '0;
  assign sram_REB = ~issue;
  assign sram_AB  = rd_ptr;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    stored_nx   = stored;
    occ_nx      = occ;
    head_nx     = head;
    inflight_nx = 1'b0;
    if (clr) begin
      wr_ptr_nx = '0;
      rd_ptr_nx = '0;
      stored_nx = '0;
      occ_nx    = '0;
      head_nx   = 1'b0;
    end else begin
      // NOTE: blocking assignments here are fine -- combinational logic, no state is held.
      if (push)  wr_ptr_nx = next_ptr(wr_ptr);
      if (issue) rd_ptr_nx = next_ptr(rd_ptr);
      stored_nx   = stored + StoredWidth'(push) - StoredWidth'(issue);
      occ_nx      = occ + {1'b0, inflight} - {1'b0, pop};
      inflight_nx = issue;
      if (pop) head_nx = ~head;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stored   <= '0;
      occ      <= '0;
      head     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      wr_ptr   <= wr_ptr_nx;
      rd_ptr   <= rd_ptr_nx;
      stored   <= stored_nx;
      occ      <= occ_nx;
      head     <= head_nx;
      inflight <= inflight_nx;
    end
  end

  // NOTE: data storage has no reset; occ alone decides whether an entry is valid.
  always_ff @(posedge CLK) begin
    if (inflight && !clr) obuf[tail] <= sram_Q;
  end

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  localparam int LevelWidth = $clog2(NUM_ROWS + 3);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) level <= '0;
    else        level <= LevelWidth'(stored_nx) + LevelWidth'(inflight_nx) + LevelWidth'(occ_nx);
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed self-checking bench for sram_fifo_ctrl with a behavioural dual-port SRAM.
// Level checks are active when SRAM_FIFO_CTRL_LEVEL_EN is defined.
module tb_sram_fifo_ctrl;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic          CLK, RST_N, clr;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic          sram_REB, sram_WEB;
  logic [AW-1:0] sram_AA, sram_AB;
  logic [W-1:0]  sram_D, sram_M, sram_Q;
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
  logic [$clog2(N+3)-1:0] level;
`endif

  int checks = 0;
  int errors = 0;

  sram_fifo_ctrl #(.WIDTH(W), .NUM_ROWS(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_REB(sram_REB), .sram_WEB(sram_WEB),
    .sram_AA(sram_AA), .sram_AB(sram_AB),
    .sram_D(sram_D), .sram_M(sram_M), .sram_Q(sram_Q)
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    , .level(level)
`endif
  );

  // Behavioural SRAM: synchronous write with bit mask, registered read that holds.
  logic [W-1:0] mem [N];
  always @(posedge CLK) begin
    if (!sram_WEB) mem[sram_AA] <= (mem[sram_AA] & sram_M) | (sram_D & ~sram_M);
    if (!sram_REB) sram_Q <= mem[sram_AB];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n, exp, sent, got, tb_occ, tb_inf;
    logic pop, found;

    // Reset state, observed before any clock edge.
    RST_N = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_reb", sram_REB, 1);
    check("rst_web", sram_WEB, 1);
    check("rst_aa", sram_AA, 0);
    check("rst_ab", sram_AB, 0);
    check_level("rst_level", 0);
    tick(); tick();
    RST_N = 1'b1;

    // Single word: three-cycle first-word latency, then empty again.
    tick();
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1; #1;
    check("a5_web", sram_WEB, 0);
    check("a5_aa", sram_AA, 0);
    check("a5_d", sram_D, 16'h00A5);
    check("a5_m", sram_M, 0);
    tick();
    in_valid = 1'b0; #1;
    check("a5_lat0_valid", out_valid, 0);
    check("a5_reb", sram_REB, 0);
    check("a5_ab", sram_AB, 0);
    tick(); #1;
    check("a5_lat1_valid", out_valid, 0);
    check("a5_reb_idle", sram_REB, 1);
    tick(); #1;
    check("a5_out_valid", out_valid, 1);
    check("a5_out_data", out_data, 16'h00A5);
    tick(); #1;
    check("a5_after_valid", out_valid, 0);

    // Fill with output stalled: 8 rows + 2 buffered accepted, the 11th refused.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0100 + i); #1;
      check("fill_in_ready", in_ready, (i < 10));
      tick();
    end
    in_valid = 1'b0; #1;
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_head", out_data, 16'h0100);
    check_level("full_level", 10);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (out_valid) begin
        check("drain_data", out_data, 32'h0100 + n);
        n++;
      end
      tick(); #1;
    end
    check("drain_count", n, 10);

    // Streaming with both sides open: one pop per cycle once the pipe is full.
    exp = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'(16'h0200 + c); #1;
      if (c >= 3) check("tput_valid", out_valid, 1);
      if (out_valid) begin
        check("tput_data", out_data, 32'h0200 + exp);
        exp++;
      end
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        check("tput_tail_data", out_data, 32'h0200 + exp);
        exp++;
      end
      tick();
    end
    check("tput_count", exp, 100);

    // Random output stalls: order kept, read issue never overruns the buffer.
    sent = 0; got = 0; tb_occ = 0; tb_inf = 0;
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      in_valid = (sent < 1000); in_data = 16'(16'h3000 + sent);
      out_ready = 1'($urandom_range(0, 1)); #1;
      pop = out_valid & out_ready;
      check("stall_valid", out_valid, (tb_occ != 0));
      if (!sram_REB) check("stall_reb_rule", ((tb_occ + tb_inf - int'(pop)) < 2), 1);
      if (pop) begin
        check("stall_data", out_data, 32'h3000 + got);
        got++;
      end
      if (in_valid && in_ready) sent++;
      tb_occ = tb_occ + tb_inf - int'(pop);
      tb_inf = int'(!sram_REB);
      tick();
    end
    check("stall_count", got, 1000);
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush with a read in flight and buffered data present.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0400 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    #1;
    check("clr_pre_valid", out_valid, 1);
    check("clr_pre_head", out_data, 16'h0400);
    check_level("clr_pre_level", 5);
    out_ready = 1'b1; #1;
    check("clr_pre_issue", sram_REB, 0);
    tick();
    out_ready = 1'b0; clr = 1'b1; #1;
    check("clr_in_ready", in_ready, 0);
    check("clr_reb", sram_REB, 1);
    check("clr_head", out_data, 16'h0401);
    tick();
    clr = 1'b0; #1;
    check("clr_out_valid", out_valid, 0);
    check("clr_reb_after", sram_REB, 1);
    check_level("clr_level", 0);
    tick(); #1;
    check("clr_discard", out_valid, 0);
    in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1; #1;
    check("clr_web", sram_WEB, 0);
    check("clr_aa", sram_AA, 0);
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (out_valid) begin
        found = 1'b1;
        check("clr_first_data", out_data, 16'hBEEF);
      end
      tick();
    end
    check("clr_first_seen", found, 1);
    #1;
    check("clr_empty_after", out_valid, 0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0500 + i);
      tick();
    end
    in_valid = 1'b1; in_data = 16'h05FF;
    #2;
    RST_N = 1'b0; #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_reb", sram_REB, 1);
    check("arst_web", sram_WEB, 1);
    check("arst_aa", sram_AA, 0);
    check("arst_ab", sram_AB, 0);
    check_level("arst_level", 0);
    tick();
    RST_N = 1'b1;
    in_valid = 1'b1; in_data = 16'hC0DE; out_ready = 1'b1; #1;
    check("arst_post_aa", sram_AA, 0);
    tick();
    in_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (out_valid) begin
        found = 1'b1;
        check("arst_first_data", out_data, 16'hC0DE);
      end
      tick();
    end
    check("arst_first_seen", found, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
